// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction prefetch stage.
package fetch_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h2000_0000;
    localparam int          INSN_BYTES   = 4;

    // Queue slot payload. The PC lives in its own XLEN-wide array so the
    // slot layout does not depend on the address width.
    typedef struct packed {
        logic [31:0] instr;
        logic        err;
        logic        filled;
    } fetch_slot_t;

endpackage

// File: rtl/fetch_prefetch.sv
// Instruction prefetch: sequential PC generation, up to DEPTH outstanding
// imem requests, and an in-order queue of returned words feeding decode.
// A redirect flushes the queue and drops responses to stale requests.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            imem_resp_err,
    output logic            fetch_o_valid,
    input  logic            fetch_o_ready,
    output logic [31:0]     fetch_o_instr,
    output logic [XLEN-1:0] fetch_o_pc,
    output logic [XLEN-1:0] fetch_o_pre_pc,
    output logic            fetch_o_err
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0]   head_q, fill_q, tail_q;
    logic [PW-1:0]   discard_q;
    logic [XLEN-1:0] fetch_pc_q;

    logic [XLEN-1:0] pc_q   [DEPTH];
    fetch_slot_t     slot_q [DEPTH];

    logic [PW-1:0]   occupancy;
    logic [IW-1:0]   head_idx, fill_idx, tail_idx;
    logic            req_fire, deq_fire, resp_keep;
    logic [PW:0]     discard_redir;

    assign head_idx  = head_q[IW-1:0];
    assign fill_idx  = fill_q[IW-1:0];
    assign tail_idx  = tail_q[IW-1:0];
    assign occupancy = tail_q - head_q;

    assign imem_req_valid = (occupancy < PW'(DEPTH)) && (discard_q == '0) && !reset;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is written only when it belongs to a live request.
    assign resp_keep = imem_resp_valid && (discard_q == '0);

    assign fetch_o_valid  = slot_q[head_idx].filled && !redirect_valid && !reset;
    assign fetch_o_instr  = slot_q[head_idx].instr;
    assign fetch_o_err    = slot_q[head_idx].err;
    assign fetch_o_pc     = pc_q[head_idx];
    assign fetch_o_pre_pc = pc_q[head_idx] + XLEN'(INSN_BYTES);
    assign deq_fire       = fetch_o_valid && fetch_o_ready;

    // Stale responses still owed by memory after a redirect: everything
    // requested but not yet returned, plus one issued this cycle, minus one
    // arriving this cycle. Computed one bit wider so the intermediate sum
    // cannot wrap before the subtraction.
    always_comb begin
        discard_redir = {1'b0, tail_q - fill_q}
                      + {1'b0, discard_q}
                      + (PW+1)'(req_fire)
                      - (PW+1)'(imem_resp_valid);
    end

    // Pointers, fetch PC and discard counter; redirect overrides all traffic.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            fill_q     <= '0;
            tail_q     <= '0;
            discard_q  <= '0;
            fetch_pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            head_q     <= '0;
            fill_q     <= '0;
            tail_q     <= '0;
            discard_q  <= discard_redir[PW-1:0];
            fetch_pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
        end else begin
            if (req_fire) begin
                tail_q     <= tail_q + PW'(1);
                fetch_pc_q <= fetch_pc_q + XLEN'(INSN_BYTES);
            end
            if (imem_resp_valid) begin
                if (discard_q != '0) discard_q <= discard_q - PW'(1);
                else                 fill_q    <= fill_q + PW'(1);
            end
            if (deq_fire) head_q <= head_q + PW'(1);
        end
    end

    // Slot storage: allocate at tail, fill in request order, clear on dequeue.
    // The three indices never collide in legal operation (full blocks issue,
    // an unfilled head cannot dequeue).
    always_ff @(posedge clock) begin
        if (reset || redirect_valid) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i].filled <= 1'b0;
        end else begin
            if (req_fire) begin
                pc_q[tail_idx]          <= fetch_pc_q;
                slot_q[tail_idx].filled <= 1'b0;
            end
            if (resp_keep) begin
                slot_q[fill_idx].instr  <= imem_resp_data;
                slot_q[fill_idx].err    <= imem_resp_err;
                slot_q[fill_idx].filled <= 1'b1;
            end
            if (deq_fire) slot_q[head_idx].filled <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with a latency-configurable imem model.
module tb_fetch_prefetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        imem_resp_err = 1'b0;
    logic        fetch_o_valid;
    logic        fetch_o_ready = 1'b0;
    logic [31:0] fetch_o_instr;
    logic [31:0] fetch_o_pc;
    logic [31:0] fetch_o_pre_pc;
    logic        fetch_o_err;

    fetch_prefetch dut (
        .clock           (clock),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .fetch_o_valid   (fetch_o_valid),
        .fetch_o_ready   (fetch_o_ready),
        .fetch_o_instr   (fetch_o_instr),
        .fetch_o_pc      (fetch_o_pc),
        .fetch_o_pre_pc  (fetch_o_pre_pc),
        .fetch_o_err     (fetch_o_err)
    );

    always #5 clock = ~clock;

    localparam logic [31:0] ERR_ADDR = 32'h2000_0008;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory model: in-order, fixed latency, response held for one cycle.
    int          mem_lat  = 1;
    int          cyc      = 0;
    int          fire_cnt = 0;
    logic [31:0] pend_addr [$];
    int          pend_cyc  [$];

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            pend_addr.delete();
            pend_cyc.delete();
        end else begin
            if (imem_resp_valid && pend_addr.size() > 0) begin
                void'(pend_addr.pop_front());
                void'(pend_cyc.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                pend_addr.push_back(imem_req_addr);
                pend_cyc.push_back(cyc);
                fire_cnt++;
            end
        end
        #1;
        if (!reset && pend_addr.size() > 0 && cyc >= pend_cyc[0] + mem_lat - 1) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_data(pend_addr[0]);
            imem_resp_err   = (pend_addr[0] == ERR_ADDR);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
            imem_resp_err   = 1'b0;
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        fetch_o_ready  = 1'b0;
        imem_req_ready = 1'b0;
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int base;
        int stale;
        int seen_valid;

        // ---- reset state, streaming with 1-cycle memory, error passthrough
        do_reset();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(fetch_o_valid), 32'd0);
        mem_lat = 1; imem_req_ready = 1'b1; fetch_o_ready = 1'b1;
        reset = 1'b0;
        #1;
        chk("s_req_valid0", 32'(imem_req_valid), 32'd1);
        chk("s_req_addr0", imem_req_addr, 32'h2000_0000);
        chk("s_out_valid0", 32'(fetch_o_valid), 32'd0);
        step();
        chk("s_req_addr1", imem_req_addr, 32'h2000_0004);
        chk("s_out_valid1", 32'(fetch_o_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] pc;
            pc = 32'h2000_0000 + 32'(4 * k);
            step();
            chk("s_valid", 32'(fetch_o_valid), 32'd1);
            chk("s_pc", fetch_o_pc, pc);
            chk("s_pre_pc", fetch_o_pre_pc, pc + 32'd4);
            chk("s_instr", fetch_o_instr, mem_data(pc));
            chk("s_err", 32'(fetch_o_err), (pc == ERR_ADDR) ? 32'd1 : 32'd0);
        end

        // ---- backpressure: decode stalled fills the queue, then one slot frees
        do_reset();
        mem_lat = 1; imem_req_ready = 1'b1; fetch_o_ready = 1'b0;
        base = fire_cnt;
        reset = 1'b0;
        for (int k = 0; k < 8; k++) step();
        chk("bp_fires", 32'(fire_cnt - base), 32'd4);
        chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
        chk("bp_head_pc", fetch_o_pc, 32'h2000_0000);
        fetch_o_ready = 1'b1;
        #1;
        chk("bp_same_cycle_blocked", 32'(imem_req_valid), 32'd0);
        step();
        chk("bp_req_valid_after", 32'(imem_req_valid), 32'd1);
        chk("bp_req_addr_after", imem_req_addr, 32'h2000_0010);
        chk("bp_head_pc_after", fetch_o_pc, 32'h2000_0004);
        fetch_o_ready = 1'b0;
        step();
        chk("bp_fires_after", 32'(fire_cnt - base), 32'd5);
        chk("bp_req_valid_full", 32'(imem_req_valid), 32'd0);

        // ---- redirect with 3 outstanding on a 5-cycle memory
        do_reset();
        mem_lat = 5; imem_req_ready = 1'b1; fetch_o_ready = 1'b1;
        reset = 1'b0;
        step(); step(); step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0013;
        #1;
        chk("rd_out_valid_redir", 32'(fetch_o_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        stale = 0; seen_valid = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (imem_req_valid) break;
            if (imem_resp_valid) stale++;
            if (fetch_o_valid) seen_valid++;
        end
        chk("rd_stale_cnt", 32'(stale), 32'd3);
        chk("rd_no_output", 32'(seen_valid), 32'd0);
        chk("rd_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rd_req_addr", imem_req_addr, 32'h8000_0010);
        for (int k = 0; k < 15; k++) begin
            if (fetch_o_valid) break;
            step();
        end
        chk("rd_out_valid", 32'(fetch_o_valid), 32'd1);
        chk("rd_out_pc", fetch_o_pc, 32'h8000_0010);
        chk("rd_out_instr", fetch_o_instr, mem_data(32'h8000_0010));

        // ---- redirect in the same cycle as a request fire and a response
        do_reset();
        mem_lat = 1; imem_req_ready = 1'b1; fetch_o_ready = 1'b0;
        reset = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1000;
        #1;
        chk("rs_fire_pre", 32'(imem_req_valid), 32'd1);
        chk("rs_resp_pre", 32'(imem_resp_valid), 32'd1);
        step();
        redirect_valid = 1'b0;
        fetch_o_ready  = 1'b1;
        chk("rs_req_blocked", 32'(imem_req_valid), 32'd0);
        chk("rs_out_valid_c2", 32'(fetch_o_valid), 32'd0);
        step();
        chk("rs_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rs_req_addr", imem_req_addr, 32'h0000_1000);
        chk("rs_out_valid_c3", 32'(fetch_o_valid), 32'd0);
        step();
        chk("rs_out_valid_c4", 32'(fetch_o_valid), 32'd0);
        step();
        chk("rs_out_valid_c5", 32'(fetch_o_valid), 32'd1);
        chk("rs_out_pc", fetch_o_pc, 32'h0000_1000);
        chk("rs_out_instr", fetch_o_instr, mem_data(32'h0000_1000));

        // ---- reset with a full queue and requests still in flight
        do_reset();
        mem_lat = 3; imem_req_ready = 1'b1; fetch_o_ready = 1'b0;
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (fetch_o_valid && !imem_req_valid) break;
        end
        chk("mr_full_valid", 32'(fetch_o_valid), 32'd1);
        chk("mr_full_req", 32'(imem_req_valid), 32'd0);
        step();
        reset = 1'b1;
        #1;
        chk("mr_rst_req", 32'(imem_req_valid), 32'd0);
        chk("mr_rst_out", 32'(fetch_o_valid), 32'd0);
        step();
        chk("mr_rst_req2", 32'(imem_req_valid), 32'd0);
        chk("mr_rst_out2", 32'(fetch_o_valid), 32'd0);
        mem_lat = 1; fetch_o_ready = 1'b1;
        reset = 1'b0;
        #1;
        chk("mr_restart_req", 32'(imem_req_valid), 32'd1);
        chk("mr_restart_addr", imem_req_addr, 32'h2000_0000);
        chk("mr_restart_out", 32'(fetch_o_valid), 32'd0);
        step();
        step();
        chk("mr_out_valid", 32'(fetch_o_valid), 32'd1);
        chk("mr_out_pc", fetch_o_pc, 32'h2000_0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
